// File: rtl/skdecode_s1s2_ctrl.sv
// skdecode_s1s2_ctrl: sequences the ML-DSA s1/s2 secret-key decode (eta = 2).
// Packed sk words arrive on a valid/ready stream into a 64-bit bit buffer.
// Each RUN cycle with at least 12 buffered bits, four 3-bit fields are taken
// and mapped (0->2, 1->1, 2->0, 3->Q-1, 4->Q-2, 5..7 invalid). Each valid group
// becomes one memory word of four coefficients, written one cycle later.
//
// Handshake: a word moves on a rising clk edge when data_valid_i and
// data_ready_o are both high; data_ready_o depends only on registered state,
// so the source may hold data_i/data_valid_i until it sees ready.
module skdecode_s1s2_ctrl #(
  parameter int IN_W       = 32,
  parameter int REG_SIZE   = 24,
  parameter int MLDSA_Q    = 8380417,
  parameter int NUM_POLY   = 15,
  parameter int MEM_ADDR_W = 15
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    zeroize,
  input  logic                    start_i,
  input  logic [MEM_ADDR_W-1:0]   base_addr_i,
  input  logic [IN_W-1:0]         data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic                    mem_we_o,
  output logic [MEM_ADDR_W-1:0]   mem_addr_o,
  output logic [4*REG_SIZE-1:0]   mem_wdata_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [1:0]              dbg_state
);

  localparam int TOTAL_WORDS  = NUM_POLY * 256 * 3 / IN_W;
  localparam int TOTAL_GROUPS = NUM_POLY * 64;
  localparam int WCNT_W       = $clog2(TOTAL_WORDS + 1);
  localparam int GCNT_W       = $clog2(TOTAL_GROUPS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t                  state_q;
  logic [63:0]             buf_q;
  logic [6:0]              cnt_q;
  logic [WCNT_W-1:0]       in_cnt_q;
  logic [GCNT_W-1:0]       grp_cnt_q;
  logic [MEM_ADDR_W-1:0]   base_q;
  logic [MEM_ADDR_W-1:0]   wr_idx_q;

  logic                    accept;
  logic                    consume;
  logic                    restart;
  logic                    group_bad;
  logic [4*REG_SIZE-1:0]   group_data;
  logic [63:0]             buf_next;
  logic [6:0]              cnt_next;
  logic [63:0]             buf_shift;
  logic [6:0]              cnt_base;

  // eta = 2 unpack of one 3-bit field; invalid codes return 0 and are flagged separately
  function automatic logic [REG_SIZE-1:0] lane_map(input logic [2:0] f);
    case (f)
      3'd0:    lane_map = REG_SIZE'(2);
      3'd1:    lane_map = REG_SIZE'(1);
      3'd2:    lane_map = '0;
      3'd3:    lane_map = REG_SIZE'(MLDSA_Q - 1);
      3'd4:    lane_map = REG_SIZE'(MLDSA_Q - 2);
      default: lane_map = '0;
    endcase
  endfunction

  assign data_ready_o = (state_q == RUN) && (cnt_q <= 7'd32) &&
                        (in_cnt_q < WCNT_W'(TOTAL_WORDS));
  assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
  assign dbg_state    = state_q;

  // Four unpack lanes on the low 12 buffer bits, plus buffer/count next-state
  always_comb begin
    group_bad  = 1'b0;
    group_data = '0;
    for (int j = 0; j < 4; j++) begin
      group_data[REG_SIZE*j +: REG_SIZE] = lane_map(buf_q[3*j +: 3]);
      if (buf_q[3*j +: 3] > 3'd4) group_bad = 1'b1;
    end
    accept    = data_valid_i && data_ready_o;
    consume   = (state_q == RUN) && (cnt_q >= 7'd12);
    restart   = start_i && ((state_q == IDLE) || (state_q == ERROR));
    buf_shift = consume ? (buf_q >> 12) : buf_q;
    cnt_base  = consume ? (cnt_q - 7'd12) : cnt_q;
    buf_next  = buf_shift;
    cnt_next  = cnt_base;
    if (accept) begin
      // new word lands directly above whatever survives this cycle's consume
      buf_next = buf_shift | ({{(64-IN_W){1'b0}}, data_i} << cnt_base);
      cnt_next = cnt_base + 7'(IN_W);
    end
  end

  // Control FSM, bit buffer, counters and registered write port
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      in_cnt_q    <= '0;
      grp_cnt_q   <= '0;
      base_q      <= '0;
      wr_idx_q    <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else if (zeroize) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      in_cnt_q    <= '0;
      grp_cnt_q   <= '0;
      base_q      <= '0;
      wr_idx_q    <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      done_o   <= 1'b0;
      if (restart) begin
        // start from IDLE or ERROR: flush leftovers and begin a fresh key
        state_q   <= RUN;
        base_q    <= base_addr_i;
        buf_q     <= '0;
        cnt_q     <= '0;
        in_cnt_q  <= '0;
        grp_cnt_q <= '0;
        wr_idx_q  <= '0;
        error_o   <= 1'b0;
      end else if (state_q == RUN) begin
        buf_q <= buf_next;
        cnt_q <= cnt_next;
        if (accept) in_cnt_q <= in_cnt_q + 1'b1;
        if (consume) begin
          if (group_bad) begin
            // malformed key: drop this group, keep earlier writes, abort
            error_o <= 1'b1;
            state_q <= ERROR;
          end else begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= base_q + wr_idx_q;
            mem_wdata_o <= group_data;
            wr_idx_q    <= wr_idx_q + 1'b1;
            grp_cnt_q   <= grp_cnt_q + 1'b1;
            if (grp_cnt_q == GCNT_W'(TOTAL_GROUPS - 1)) begin
              // final write is visible in DRAIN alongside the done pulse
              state_q <= DRAIN;
              done_o  <= 1'b1;
            end
          end
        end
      end else if (state_q == DRAIN) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_skdecode_s1s2_ctrl.sv
// tb_skdecode_s1s2_ctrl: scoreboard bench for the s1/s2 decode controller.
// A group-level model turns every accepted word into expected memory writes
// (address + four coefficients); the write monitor pops and compares them.
module tb_skdecode_s1s2_ctrl;

  localparam int AW      = 15;
  localparam int RS      = 24;
  localparam int Q       = 8380417;
  localparam int NGROUPS = 960;
  localparam int NCOEFF  = 3840;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              zeroize = 1'b0;
  logic              start_i = 1'b0;
  logic [AW-1:0]     base_addr_i = '0;
  logic [31:0]       data_i = '0;
  logic              data_valid_i = 1'b0;
  logic              data_ready_o;
  logic              mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [4*RS-1:0]   mem_wdata_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  skdecode_s1s2_ctrl dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .zeroize      (zeroize),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .dbg_state    (dbg_state)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [AW+4*RS-1:0] exp_q[$];
  logic [95:0]        m_buf;
  int                 m_cnt;
  int                 m_idx;
  logic [AW-1:0]      m_base;
  bit                 m_err;
  logic [31:0]        wq[$];
  int                 writes = 0;
  int                 done_cnt = 0;
  bit                 abort = 1'b0;

  function automatic logic [RS-1:0] ref_coeff(input logic [2:0] f);
    case (f)
      3'd0:    ref_coeff = 24'd2;
      3'd1:    ref_coeff = 24'd1;
      3'd2:    ref_coeff = 24'd0;
      3'd3:    ref_coeff = 24'(Q - 1);
      default: ref_coeff = 24'(Q - 2);
    endcase
  endfunction

  task automatic model_reset(input logic [AW-1:0] b);
    exp_q.delete();
    m_buf  = '0;
    m_cnt  = 0;
    m_idx  = 0;
    m_base = b;
    m_err  = 1'b0;
  endtask

  task automatic model_push_word(input logic [31:0] w);
    logic [4*RS-1:0] d;
    logic [AW-1:0]   a;
    bit              bad;
    m_buf = m_buf | ({64'b0, w} << m_cnt);
    m_cnt += 32;
    while (m_cnt >= 12 && !m_err) begin
      bad = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (m_buf[3*j +: 3] > 3'd4) bad = 1'b1;
        d[RS*j +: RS] = ref_coeff(m_buf[3*j +: 3]);
      end
      if (bad) begin
        m_err = 1'b1;
      end else begin
        a = m_base + AW'(m_idx);
        exp_q.push_back({a, d});
        m_idx++;
      end
      m_buf = m_buf >> 12;
      m_cnt -= 12;
    end
  endtask

  // Random stream of valid coefficients; bad_at >= 0 plants code 5 there
  task automatic gen_stream(input int bad_at);
    logic [63:0] acc;
    int          ac;
    logic [2:0]  v;
    wq.delete();
    acc = '0;
    ac  = 0;
    for (int n = 0; n < NCOEFF; n++) begin
      v = (n == bad_at) ? 3'd5 : 3'($urandom_range(0, 4));
      acc = acc | (64'(v) << ac);
      ac += 3;
      if (ac >= 32) begin
        wq.push_back(acc[31:0]);
        acc = acc >> 32;
        ac -= 32;
      end
    end
  endtask

  // Write monitor: pop and compare each DUT write, count done pulses
  always @(negedge clk) begin
    logic [AW+4*RS-1:0] e;
    if (rst_b) begin
      if (mem_we_o) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr_o, e[AW+4*RS-1:4*RS]);
          check("wr_data", mem_wdata_o, e[4*RS-1:0]);
        end
      end
      if (done_o) done_cnt++;
      if (data_ready_o && dbg_state != ST_RUN) check("ready_outside_run", 1, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [AW-1:0] b);
    @(posedge clk); #1;
    base_addr_i = b;
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    model_reset(b);
    pulse_start(b);
  endtask

  task automatic send_word(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    data_i       = w;
    data_valid_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (abort) break;
      if (data_ready_o) begin
        model_push_word(w);
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    data_valid_i = 1'b0;
    if (!ok && !abort) check("ready_timeout", 0, 1);
  endtask

  task automatic send_all();
    bit ok;
    for (int i = 0; i < wq.size(); i++) begin
      send_word(wq[i], ok);
      if (!ok) break;
    end
  endtask

  task automatic do_zeroize();
    @(posedge clk); #1;
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check("zero_outs", {data_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, error_o}, '0);
    check("zero_state", dbg_state, ST_IDLE);
    model_reset('0);
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int c = 0; c < budget && done_cnt == d0; c++) @(negedge clk);
    check("done_seen", done_cnt > d0, 1);
  endtask

  task automatic full_run(input logic [AW-1:0] b, input bit pulse_mid);
    int w0, d0;
    gen_stream(-1);
    w0 = writes;
    d0 = done_cnt;
    do_start(b);
    check("run_busy", {busy_o, dbg_state}, {1'b1, ST_RUN});
    fork
      send_all();
      begin
        if (pulse_mid) begin
          for (int c = 0; c < 4000 && writes - w0 < 300; c++) @(negedge clk);
          pulse_start(15'h1234);
        end
      end
    join
    wait_done(d0, 3000);
    repeat (3) @(negedge clk);
    check("run_writes", writes - w0, NGROUPS);
    check("run_done_once", done_cnt - d0, 1);
    check("run_q_empty", exp_q.size(), 0);
    check("run_no_error", error_o, 0);
    check("run_idle", {busy_o, data_ready_o, dbg_state}, {2'b00, ST_IDLE});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w0;
    bit ok;
    model_reset('0);
    repeat (3) @(negedge clk);
    check("reset_outs", {data_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, error_o}, '0);
    check("reset_state", dbg_state, ST_IDLE);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {busy_o, data_ready_o, dbg_state}, {2'b00, ST_IDLE});

    // Known group: fields 0,1,2,3 then 4,0,0,0 at base 0x100
    w0 = writes;
    do_start(15'h100);
    send_word(32'h0000_4688, ok);
    repeat (6) @(negedge clk);
    check("kg_writes", writes - w0, 2);
    check("kg_q_empty", exp_q.size(), 0);
    do_zeroize();

    // Asynchronous reset in the middle of a run
    gen_stream(-1);
    do_start(15'h2000);
    send_word(wq[0], ok);
    send_word(wq[1], ok);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("midrst_outs", {data_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, error_o}, '0);
    check("midrst_state", dbg_state, ST_IDLE);
    model_reset('0);
    w0 = writes;
    rst_b = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_writes", writes - w0, 0);
    check("midrst_idle", dbg_state, ST_IDLE);

    // Full run with address wrap and an ignored start mid-run
    full_run(15'h7F00, 1'b1);

    // Malformed key: code 5 at coefficient 10
    gen_stream(10);
    w0 = writes;
    do_start(15'h0300);
    send_word(wq[0], ok);
    send_word(wq[1], ok);
    repeat (10) @(negedge clk);
    check("err_writes", writes - w0, 2);
    check("err_q_empty", exp_q.size(), 0);
    check("err_flags", {error_o, data_ready_o, busy_o, dbg_state}, {3'b100, ST_ERROR});
    repeat (5) @(negedge clk);
    check("err_sticky", error_o, 1);

    // Restart from ERROR, then zeroize after 500 writes
    gen_stream(-1);
    w0 = writes;
    do_start(15'h0500);
    check("restart_clears", {error_o, dbg_state}, {1'b0, ST_RUN});
    fork
      send_all();
      begin
        for (int c = 0; c < 5000 && writes - w0 < 500; c++) @(negedge clk);
        check("z_reached_500", writes - w0 >= 500, 1);
        abort = 1'b1;
        do_zeroize();
      end
    join
    abort = 1'b0;
    w0 = writes;
    repeat (10) @(negedge clk);
    check("z_no_writes", writes - w0, 0);

    // Clean full run after zeroize
    full_run(15'h0040, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
